// File: rtl/adder_seq_ctrl.sv
// Multi-precision add/subtract sequencer: streams WORDS x 16-bit words through one
// shared combinational 16-bit adder, least significant word first, carrying between words.

module adder_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        ci,
    output logic [15:0] s,
    output logic        co
);
    assign {co, s} = {1'b0, a} + {1'b0, b} + {16'b0, ci};
endmodule

module adder_seq_ctrl #(
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                sub,
    input  logic [16*WORDS-1:0] a,
    input  logic [16*WORDS-1:0] b,
    input  logic                cin,
    output logic                busy,
    output logic                done,
    output logic [16*WORDS-1:0] sum,
    output logic                cout,
    output logic                ovf
);
    localparam int W  = 16 * WORDS;
    localparam int IW = $clog2(WORDS);
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic            sub_q, sub_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;

    logic [15:0]     a_word;
    logic [15:0]     b_word;
    logic [15:0]     add_s;
    logic            add_co;

    // B is inverted here for subtraction; the +1 comes from the preloaded carry.
    assign a_word = a_q[{idx_q, 4'b0000} +: 16];
    assign b_word = b_q[{idx_q, 4'b0000} +: 16] ^ {16{sub_q}};

    adder_16bit u_adder (
        .a  (a_word),
        .b  (b_word),
        .ci (carry_q),
        .s  (add_s),
        .co (add_co)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        busy    = 1'b0;
        done    = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                done = (state_q == DONE);
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sub_d   = sub;
                    carry_d = sub | cin;
                    idx_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                busy = 1'b1;
                sum_d[{idx_q, 4'b0000} +: 16] = add_s;
                carry_d = add_co;
                if (idx_q == LAST_IDX) begin
                    cout_d  = add_co;
                    ovf_d   = (a_word[15] == b_word[15]) && (add_s[15] != a_word[15]);
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed bench for adder_seq_ctrl (WORDS=4): latency, carry ripple, subtract,
// overflow, back-to-back starts, ignored mid-run starts and reset abort.

module tb_adder_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sub;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    adder_seq_ctrl #(.WORDS(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    task automatic chk(input string tag, input logic [66:0] obs, input logic [66:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; the request is sampled at the next rising edge.
    task automatic launch(input logic [63:0] av, input logic [63:0] bv,
                          input logic cv, input logic sv);
        a = av; b = bv; cin = cv; sub = sv; start = 1'b1;
    endtask

    // Follows one accepted request: four busy cycles, then the done cycle.
    // With poke set, a stray start carrying other operands is driven mid-run.
    task automatic expect_run(input string tag, input logic [63:0] es,
                              input logic ec, input logic eo, input bit poke);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'b0;
            a = 64'hDEAD_BEEF_0BAD_F00D;
            b = 64'h1234_5678_9ABC_DEF0;
            if (poke && i == 1) begin
                start = 1'b1;
                cin = 1'b1;
            end
            chk({tag, " busy/done run"}, {65'b0, busy, done}, 67'b10);
        end
        @(negedge clk);
        start = 1'b0;
        chk({tag, " busy/done end"}, {65'b0, busy, done}, 67'b01);
        chk({tag, " sum/cout/ovf"}, {sum, cout, ovf}, {es, ec, eo});
        $display("op %s: sum=%h cout=%0b ovf=%0b", tag, sum, cout, ovf);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("reset idle", {busy, done, sum, cout}, {ovf, 66'b0});
            chk("reset idle ovf", {66'b0, ovf}, 67'b0);
        end

        launch(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0);
        expect_run("ripple", 64'h0, 1'b1, 1'b0, 1'b0);

        @(negedge clk);
        chk("idle after done", {65'b0, busy, done}, 67'b0);
        launch(64'h0000_0001_0000_0000, 64'h1, 1'b0, 1'b1);
        expect_run("sub borrow", 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b0, 1'b0);

        @(negedge clk);
        launch(64'h0, 64'h1, 1'b0, 1'b1);
        expect_run("sub neg", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        launch(64'h5, 64'h3, 1'b1, 1'b1);
        expect_run("sub cin ignored", 64'h2, 1'b1, 1'b0, 1'b0);

        @(negedge clk);
        launch(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        expect_run("ovf", 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);

        // Back-to-back: the second start lands in the DONE cycle of the first.
        @(negedge clk);
        launch(64'd10, 64'd20, 1'b0, 1'b0);
        expect_run("b2b first", 64'd30, 1'b0, 1'b0, 1'b0);
        launch(64'd3, 64'd4, 1'b0, 1'b0);
        expect_run("b2b second", 64'd7, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("no extra done", {65'b0, busy, done}, 67'b0);
        @(negedge clk);
        chk("still idle", {busy, done, sum}, {2'b0, 65'd7});

        // Reset two cycles into a run clears everything without waiting for a clock edge.
        launch(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        repeat (2) begin
            @(negedge clk);
            start = 1'b0;
            chk("pre-abort busy", {66'b0, busy}, 67'b1);
        end
        #2 rst = 1'b1;
        #1 chk("async abort", {busy, done, sum, cout}, {ovf, 66'b0});
        chk("async abort ovf", {66'b0, ovf}, 67'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("after abort idle", {65'b0, busy, done}, 67'b0);
        launch(64'd5, 64'd6, 1'b0, 1'b0);
        expect_run("after reset", 64'd11, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
